config_frame_loader: RTL and testbench

- Parametrised, clocked successor to the level-sensitive configuration latch bank.
- Accepts a stream of WORD_W-bit configuration words over a valid/ready handshake, in either burst mode (auto-incrementing from a start address) or single-word addressed mode.
- Stores the words in NUM_WORDS flop-based registers and drives the concatenated configuration vector to the LUT tile.
- Adds a lock, readback, word counting and an overrun error flag.

---
 rtl/config_loader_pkg.sv | 14 +
 rtl/config_word_reg.sv | 27 ++
 rtl/config_frame_loader.sv | 137 +++++++++++++
 tb/tb_config_frame_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the configuration frame loader.
package config_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    function automatic int cfg_bits(input int word_w, input int num_words);
        return word_w * num_words;
    endfunction

endpackage

// File: rtl/config_word_reg.sv
// One configuration word: flop register with synchronous active-low clear and write enable.
module config_word_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] q_q;
    logic [WORD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (we) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/config_frame_loader.sv
// Streams configuration words into a flop bank (burst or single-word addressed),
// with lock, registered readback, word count and sticky overrun/illegal-start error.
module config_frame_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 12,
    parameter int ADDR_W    = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      io_start,
    input  logic                                      io_mode,
    input  logic [ADDR_W-1:0]                         io_base_addr,
    input  logic [ADDR_W:0]                           io_burst_len,
    input  logic                                      io_d_valid,
    input  logic [WORD_W-1:0]                         io_d_in,
    output logic                                      io_d_ready,
    input  logic                                      io_lock,
    input  logic [ADDR_W-1:0]                         io_rd_addr,
    output logic [WORD_W-1:0]                         io_rd_data,
    output logic [cfg_bits(WORD_W, NUM_WORDS)-1:0]    io_configs_out,
    output logic                                      io_busy,
    output logic                                      io_done,
    output logic                                      io_err,
    output logic [ADDR_W:0]                           io_words_loaded
);

    // Wide enough to hold base + len without overflow.
    localparam int SW = ADDR_W + 2;

    state_e                              state_q, state_d;
    logic [ADDR_W-1:0]                   ptr_q, ptr_d;
    logic [ADDR_W:0]                     cnt_q, cnt_d;
    logic [ADDR_W:0]                     len_q, len_d;
    logic                                err_q, err_d;
    logic [WORD_W-1:0]                   rd_data_q, rd_data_d;

    logic [NUM_WORDS-1:0][WORD_W-1:0]    words;
    logic [NUM_WORDS-1:0]                we;
    logic                                xfer;
    logic [ADDR_W:0]                     eff_len;
    logic [ADDR_W:0]                     cnt_inc;
    logic [SW-1:0]                       end_addr;
    logic                                start_bad;

    assign eff_len   = io_mode ? (ADDR_W+1)'(1) : io_burst_len;
    assign end_addr  = SW'(io_base_addr) + SW'(eff_len);
    assign start_bad = (SW'(io_base_addr) >= SW'(NUM_WORDS)) ||
                       (eff_len == '0) ||
                       (end_addr > SW'(NUM_WORDS));
    assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        xfer    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_d_valid) err_d = 1'b1;
                // A legal start clears the error even if a stray word arrives alongside it.
                if (io_start && !io_lock) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = io_base_addr;
                        cnt_d   = '0;
                        len_d   = eff_len;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (io_d_valid) begin
                    xfer  = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (io_d_valid) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (io_rd_addr == ADDR_W'(k)) rd_data_d = words[k];
        end
    end

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        assign we[k] = xfer && (ptr_q == ADDR_W'(k));
        config_word_reg #(.WORD_W(WORD_W)) u_reg (
            .clk   (clk),
            .clr_n (reset),
            .we    (we[k]),
            .d     (io_d_in),
            .q     (words[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign io_d_ready      = (state_q == S_LOAD);
    assign io_busy         = (state_q == S_LOAD);
    assign io_done         = (state_q == S_DONE);
    assign io_err          = err_q;
    assign io_words_loaded = cnt_q;
    assign io_rd_data      = rd_data_q;
    assign io_configs_out  = words;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: table-driven gap test plus hand-written frame sequences.
module tb_config_frame_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 12;
    localparam int ADDR_W    = 4;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           io_start;
    logic                           io_mode;
    logic [ADDR_W-1:0]              io_base_addr;
    logic [ADDR_W:0]                io_burst_len;
    logic                           io_d_valid;
    logic [WORD_W-1:0]              io_d_in;
    logic                           io_d_ready;
    logic                           io_lock;
    logic [ADDR_W-1:0]              io_rd_addr;
    logic [WORD_W-1:0]              io_rd_data;
    logic [WORD_W*NUM_WORDS-1:0]    io_configs_out;
    logic                           io_busy;
    logic                           io_done;
    logic                           io_err;
    logic [ADDR_W:0]                io_words_loaded;

    int n_chk  = 0;
    int n_fail = 0;

    logic [NUM_WORDS-1:0][WORD_W-1:0] exp_cfg;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        exp_rdy;
        logic [4:0]  exp_cnt;
        logic        exp_done;
    } gap_vec_t;

    gap_vec_t tbl [6];

    config_frame_loader #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_start        (io_start),
        .io_mode         (io_mode),
        .io_base_addr    (io_base_addr),
        .io_burst_len    (io_burst_len),
        .io_d_valid      (io_d_valid),
        .io_d_in         (io_d_in),
        .io_d_ready      (io_d_ready),
        .io_lock         (io_lock),
        .io_rd_addr      (io_rd_addr),
        .io_rd_data      (io_rd_data),
        .io_configs_out  (io_configs_out),
        .io_busy         (io_busy),
        .io_done         (io_done),
        .io_err          (io_err),
        .io_words_loaded (io_words_loaded)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic mode, input int base, input int len);
        io_start     = 1'b1;
        io_mode      = mode;
        io_base_addr = ADDR_W'(base);
        io_burst_len = (ADDR_W+1)'(len);
        step();
        io_start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; io_start = 1'b0; io_mode = 1'b0; io_base_addr = '0;
        io_burst_len = '0; io_d_valid = 1'b0; io_d_in = '0; io_lock = 1'b0; io_rd_addr = '0;
        exp_cfg = '0;

        tbl[0] = '{1'b1, 32'hA000_0000, 1'b1, 5'd1, 1'b0};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 5'd1, 1'b0};
        tbl[2] = '{1'b1, 32'hA000_0002, 1'b1, 5'd2, 1'b0};
        tbl[3] = '{1'b1, 32'hA000_0003, 1'b1, 5'd3, 1'b0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b0};
        tbl[5] = '{1'b1, 32'hA000_0005, 1'b1, 5'd4, 1'b1};

        // Reset state
        step(); step();
        chk("rst_cfg",   io_configs_out, '0);
        chk("rst_rdy",   io_d_ready, 0);
        chk("rst_busy",  io_busy, 0);
        chk("rst_done",  io_done, 0);
        chk("rst_err",   io_err, 0);
        chk("rst_cnt",   io_words_loaded, 0);
        chk("rst_rd",    io_rd_data, 0);
        reset = 1'b1;

        // Full burst, valid held high
        start_frame(1'b0, 0, 12);
        chk("burst_busy", io_busy, 1);
        for (int k = 0; k < 12; k++) begin
            io_d_valid = 1'b1;
            io_d_in    = 32'h1000_0000 + k;
            exp_cfg[k] = 32'h1000_0000 + k;
            chk($sformatf("burst_rdy%0d", k), io_d_ready, 1);
            step();
        end
        io_d_valid = 1'b0;
        chk("burst_done", io_done, 1);
        chk("burst_rdy_off", io_d_ready, 0);
        chk("burst_cnt", io_words_loaded, 12);
        chk("burst_cfg", io_configs_out, exp_cfg);
        step();
        chk("burst_done_once", io_done, 0);
        chk("burst_cnt_hold", io_words_loaded, 12);
        chk("burst_err", io_err, 0);

        // Single-word mode with len=0 (ignored), same-cycle read of the word being written
        start_frame(1'b1, 5, 0);
        chk("single_busy", io_busy, 1);
        io_d_valid = 1'b1; io_d_in = 32'hDEAD_BEEF; io_rd_addr = 4'd5;
        step();
        io_d_valid = 1'b0;
        chk("single_rd_old", io_rd_data, 32'h1000_0005);
        chk("single_done", io_done, 1);
        chk("single_cnt", io_words_loaded, 1);
        exp_cfg[5] = 32'hDEAD_BEEF;
        chk("single_cfg", io_configs_out, exp_cfg);
        step();
        chk("single_rd_new", io_rd_data, 32'hDEAD_BEEF);
        io_rd_addr = 4'd12;
        step();
        chk("rd_oob", io_rd_data, 0);
        io_rd_addr = 4'd0;
        step();
        chk("rd_w0", io_rd_data, 32'h1000_0000);

        // Gaps: base=3 len=4 with valid pattern 1,0,1,1,0,1
        start_frame(1'b0, 3, 4);
        for (int i = 0; i < 6; i++) begin
            io_d_valid = tbl[i].v;
            io_d_in    = tbl[i].d;
            chk($sformatf("gap_rdy%0d", i), io_d_ready, tbl[i].exp_rdy);
            step();
            chk($sformatf("gap_cnt%0d", i), io_words_loaded, tbl[i].exp_cnt);
            chk($sformatf("gap_done%0d", i), io_done, tbl[i].exp_done);
        end
        io_d_valid = 1'b0;
        exp_cfg[3] = 32'hA000_0000;
        exp_cfg[4] = 32'hA000_0002;
        exp_cfg[5] = 32'hA000_0003;
        exp_cfg[6] = 32'hA000_0005;
        chk("gap_cfg", io_configs_out, exp_cfg);
        step();
        chk("gap_err", io_err, 0);

        // Illegal starts: overrun end, zero length
        start_frame(1'b0, 10, 4);
        chk("ill_err", io_err, 1);
        chk("ill_busy", io_busy, 0);
        chk("ill_cfg", io_configs_out, exp_cfg);
        start_frame(1'b0, 2, 0);
        chk("ill_len0_busy", io_busy, 0);
        // Last-word boundary: base+len == NUM_WORDS is legal
        start_frame(1'b0, 11, 1);
        chk("legal_err_clr", io_err, 0);
        chk("legal_busy", io_busy, 1);
        io_d_valid = 1'b1; io_d_in = 32'h5555_AAAA;
        step();
        io_d_valid = 1'b0;
        exp_cfg[11] = 32'h5555_AAAA;
        chk("edge_done", io_done, 1);
        chk("edge_cfg", io_configs_out, exp_cfg);
        step();

        // Lock gates start; valid in IDLE is an overrun
        io_lock = 1'b1;
        start_frame(1'b0, 0, 2);
        chk("lock_busy", io_busy, 0);
        chk("lock_err", io_err, 0);
        io_lock = 1'b0;
        io_d_valid = 1'b1; io_d_in = 32'h0BAD_0BAD;
        step();
        io_d_valid = 1'b0;
        chk("ovr_err", io_err, 1);
        chk("ovr_cfg", io_configs_out, exp_cfg);
        step();
        chk("ovr_sticky", io_err, 1);

        // Reset after 3 of 8 words
        start_frame(1'b0, 0, 8);
        chk("mid_err_clr", io_err, 0);
        for (int k = 0; k < 3; k++) begin
            io_d_valid = 1'b1; io_d_in = 32'h7700_0000 + k;
            step();
        end
        chk("mid_cnt3", io_words_loaded, 3);
        io_d_valid = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        exp_cfg = '0;
        chk("mid_cfg", io_configs_out, '0);
        chk("mid_busy", io_busy, 0);
        chk("mid_rdy", io_d_ready, 0);
        chk("mid_cnt", io_words_loaded, 0);
        chk("mid_rd", io_rd_data, 0);

        start_frame(1'b0, 0, 8);
        for (int k = 0; k < 8; k++) begin
            io_d_valid = 1'b1; io_d_in = 32'h3300_0000 + k;
            exp_cfg[k] = 32'h3300_0000 + k;
            step();
        end
        io_d_valid = 1'b0;
        chk("post_done", io_done, 1);
        chk("post_cnt", io_words_loaded, 8);
        chk("post_cfg", io_configs_out, exp_cfg);
        step();
        chk("post_idle", io_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
